useq_sequencer: RTL

//   Microsequencer for the cosine-similarity microprogram. Owns the PC into the

---
 rtl/useq_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/useq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : useq_sequencer
// Purpose  : Microsequencer for the cosine-similarity microprogram. Owns the
//            PC into the control-store ROM, decodes each 32-bit
//            microinstruction, issues its control word to the datapath and
//            handles jumps, counted loops, datapath stalls and the start/done
//            handshake with the accelerator front-end.
// Ports    : clk_i        - clock
//            rst_ni       - asynchronous reset, active low
//            start_i      - launch microprogram (sampled in IDLE only)
//            vec_len_i    - element count, sampled with start_i
//            pc_o         - registered control-store address
//            instr_i      - control-store data for pc_o (same cycle)
//            dp_ready_i   - datapath can accept a control word
//            ctrl_o       - control word while issuing, else 0
//            ctrl_valid_o - ctrl_o issued this cycle
//            busy_o       - high in RUN and DONE
//            done_o       - one-cycle completion pulse
//            err_o        - sticky PC-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module useq_sequencer #(
   parameter int unsigned W      = 4,
   parameter int unsigned LOOP_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [LOOP_W-1:0] vec_len_i,
   output logic [W-1:0]      pc_o,
   input  logic [31:0]       instr_i,
   input  logic              dp_ready_i,
   output logic [23:0]       ctrl_o,
   output logic              ctrl_valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [1:0] c_OP_NEXT = 2'b00;
   localparam logic [1:0] c_OP_JUMP = 2'b01;
   localparam logic [1:0] c_OP_LOOP = 2'b10;
   localparam logic [1:0] c_OP_HALT = 2'b11;

   state_e            state_q, state_d;
   logic [W-1:0]      pc_q, pc_d;
   logic [LOOP_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              busy_q, done_q;

   logic [1:0]        w_op;
   logic [W-1:0]      w_target;
   logic              w_wait;
   logic              w_stall;
   logic              w_issue;
   logic              w_pc_last;
   logic              w_unused;

   assign w_op      = instr_i[31:30];
   assign w_target  = instr_i[26 +: W];
   assign w_wait    = instr_i[24];
   assign w_stall   = w_wait & ~dp_ready_i;
   assign w_issue   = (state_q == S_RUN) & ~w_stall;
   assign w_pc_last = (pc_q == {W{1'b1}});
   // Reserved bit and target bits above W carry no meaning here.
   assign w_unused  = ^{instr_i[25], instr_i[29:26]};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d = 1'b0;
               if (vec_len_i != '0) begin
                  pc_d    = '0;
                  cnt_d   = vec_len_i;
                  state_d = S_RUN;
               end else begin
                  // Empty vector: finish without touching the datapath.
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (w_issue) begin
               case (w_op)
                  c_OP_NEXT: begin
                     // Running off the end of the ROM aborts instead of wrapping.
                     if (w_pc_last) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        pc_d = pc_q + W'(1);
                     end
                  end
                  c_OP_JUMP: pc_d = w_target;
                  c_OP_LOOP: begin
                     cnt_d = cnt_q - LOOP_W'(1);
                     if (cnt_q != LOOP_W'(1)) begin
                        pc_d = w_target;
                     end else if (w_pc_last) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        pc_d = pc_q + W'(1);
                     end
                  end
                  c_OP_HALT: state_d = S_DONE;
                  default:   state_d = S_DONE;
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            pc_d    = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   // Control word follows the combinational ROM output so each instruction
   // issues in the cycle its address is presented.
   assign pc_o         = pc_q;
   assign ctrl_o       = w_issue ? instr_i[23:0] : 24'h0;
   assign ctrl_valid_o = w_issue;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule
`default_nettype wire
